kpyd_scan_driver: RTL and testbench

Drives the column strobes of a rows_p x cols_p keypad matrix and samples its row return lines. It debounces the scanned result across whole sweeps and emits one key code per press over a valid/ready interface. This is the matrix-facing end of the keypad path, producing debounced key events for downstream edge and consumer logic.

---
 rtl/kpyd_scan_driver.sv | 203 ++++++++++++++++++++
 tb/tb_kpyd_scan_driver.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/kpyd_scan_driver.sv
// Keypad matrix scanner: strobes columns, samples synchronized rows, debounces whole sweeps
// and emits one key code per press over valid/ready. Optional auto-repeat: KPYD_SCAN_REPEAT_EN.
module kpyd_scan_driver #(
  parameter int unsigned cols_p     = 4,
  parameter int unsigned rows_p     = 4,
  parameter int unsigned settle_p   = 4,
  parameter int unsigned debounce_p = 3,
  parameter int unsigned repeat_p   = 8
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [rows_p-1:0]                 row_i,
  output logic [cols_p-1:0]                 col_o,
  output logic [$clog2(rows_p*cols_p)-1:0]  key_o,
  output logic                              v_o,
  input  logic                              ready_i,
  output logic                              pressed_o
);

  localparam int unsigned keys_lp    = rows_p * cols_p;
  localparam int unsigned key_w_lp   = $clog2(keys_lp);
  localparam int unsigned col_w_lp   = $clog2(cols_p);
  localparam int unsigned dwell_w_lp = $clog2(settle_p);
  localparam int unsigned cnt_w_lp   = $clog2(debounce_p + 1);

  localparam logic [col_w_lp-1:0]   col_last_lp   = col_w_lp'(cols_p - 1);
  localparam logic [dwell_w_lp-1:0] dwell_last_lp = dwell_w_lp'(settle_p - 1);
  localparam logic [cnt_w_lp-1:0]   cnt_max_lp    = cnt_w_lp'(debounce_p);

  if (cols_p < 2 || rows_p < 2 || settle_p < 2 || debounce_p < 1 || repeat_p < 1) begin : g_param_check
    $error("kpyd_scan_driver: parameter out of range");
  end

  typedef enum logic [1:0] {idle_s, press_s, hold_s} state_e;

  logic [rows_p-1:0]     row_s1_q, row_s1_d, row_s2_q, row_s2_d;
  logic [col_w_lp-1:0]   col_q, col_d;
  logic [dwell_w_lp-1:0] dwell_q, dwell_d;
  logic [keys_lp-1:0]    snap_q, snap_d;
  logic                  prev_hit_q, prev_hit_d;
  logic [key_w_lp-1:0]   prev_key_q, prev_key_d;
  logic [cnt_w_lp-1:0]   cnt_q, cnt_d;
  state_e                state_q, state_d;
  logic [key_w_lp-1:0]   key_q, key_d;
  logic                  v_q, v_d;
  logic                  pressed_q, pressed_d;

`ifdef KPYD_SCAN_REPEAT_EN
  localparam int unsigned rpt_w_lp = $clog2(repeat_p + 1);
  localparam logic [rpt_w_lp-1:0] rpt_last_lp = rpt_w_lp'(repeat_p - 1);
  logic [rpt_w_lp-1:0] rpt_q, rpt_d;
`endif

  logic                dwell_last;
  logic                sweep_done;
  logic [keys_lp-1:0]  sweep_bits;
  logic                res_hit;
  logic [key_w_lp-1:0] res_key;
  logic                key_evt;
  logic                none_evt;

  // Scan timing, snapshot and lowest-code resolution
  always_comb begin
    row_s1_d   = row_i;
    row_s2_d   = row_s1_q;
    dwell_last = (dwell_q == dwell_last_lp);
    sweep_done = dwell_last && (col_q == col_last_lp);
    dwell_d    = dwell_last ? '0 : dwell_q + 1'b1;
    col_d      = col_q;
    if (dwell_last) begin
      col_d = (col_q == col_last_lp) ? '0 : col_q + 1'b1;
    end
    // The current column's rows are merged here so the wrap cycle sees a complete sweep.
    sweep_bits = snap_q;
    for (int unsigned c = 0; c < cols_p; c++) begin
      if (c == 32'(col_q)) begin
        sweep_bits[c*rows_p +: rows_p] = ~row_s2_q;
      end
    end
    snap_d = dwell_last ? sweep_bits : snap_q;

    res_hit = 1'b0;
    res_key = '0;
    for (int unsigned k = 0; k < keys_lp; k++) begin
      if (sweep_bits[k] && !res_hit) begin
        res_hit = 1'b1;
        res_key = key_w_lp'(k);
      end
    end
  end

  // Sweep-to-sweep debounce
  always_comb begin
    prev_hit_d = prev_hit_q;
    prev_key_d = prev_key_q;
    cnt_d      = cnt_q;
    if (sweep_done) begin
      prev_hit_d = res_hit;
      prev_key_d = res_key;
      if ({res_hit, res_key} == {prev_hit_q, prev_key_q}) begin
        cnt_d = (cnt_q == cnt_max_lp) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cnt_d = cnt_w_lp'(1);
      end
    end
    key_evt  = sweep_done && (cnt_d == cnt_max_lp) && res_hit;
    none_evt = sweep_done && (cnt_d == cnt_max_lp) && !res_hit;
  end

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    v_d       = v_q;
    pressed_d = pressed_q;
`ifdef KPYD_SCAN_REPEAT_EN
    rpt_d     = (state_q == hold_s) ? rpt_q : '0;
`endif
    case (state_q)
      idle_s: begin
        if (key_evt) begin
          state_d   = press_s;
          key_d     = res_key;
          v_d       = 1'b1;
          pressed_d = 1'b1;
        end
      end
      press_s: begin
        if (none_evt) begin
          pressed_d = 1'b0;
        end
        // A release debounced before the handshake skips hold_s.
        if (v_q && ready_i) begin
          v_d     = 1'b0;
          state_d = pressed_d ? hold_s : idle_s;
        end
      end
      hold_s: begin
        if (none_evt) begin
          pressed_d = 1'b0;
          state_d   = idle_s;
        end
`ifdef KPYD_SCAN_REPEAT_EN
        else if (sweep_done) begin
          if (res_hit && (res_key == key_q)) begin
            if (rpt_q == rpt_last_lp) begin
              rpt_d   = '0;
              state_d = press_s;
              v_d     = 1'b1;
            end else begin
              rpt_d = rpt_q + 1'b1;
            end
          end else begin
            rpt_d = '0;
          end
        end
`endif
      end
      default: state_d = idle_s;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      row_s1_q   <= '1;
      row_s2_q   <= '1;
      col_q      <= '0;
      dwell_q    <= '0;
      snap_q     <= '0;
      prev_hit_q <= 1'b0;
      prev_key_q <= '0;
      cnt_q      <= '0;
      state_q    <= idle_s;
      key_q      <= '0;
      v_q        <= 1'b0;
      pressed_q  <= 1'b0;
`ifdef KPYD_SCAN_REPEAT_EN
      rpt_q      <= '0;
`endif
    end else begin
      row_s1_q   <= row_s1_d;
      row_s2_q   <= row_s2_d;
      col_q      <= col_d;
      dwell_q    <= dwell_d;
      snap_q     <= snap_d;
      prev_hit_q <= prev_hit_d;
      prev_key_q <= prev_key_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      key_q      <= key_d;
      v_q        <= v_d;
      pressed_q  <= pressed_d;
`ifdef KPYD_SCAN_REPEAT_EN
      rpt_q      <= rpt_d;
`endif
    end
  end

  assign col_o     = ~(cols_p'(1) << col_q);
  assign key_o     = key_q;
  assign v_o       = v_q;
  assign pressed_o = pressed_q;

endmodule

// File: tb/tb_kpyd_scan_driver.sv
// Scoreboard bench for kpyd_scan_driver (default build): a keypad model drives row_i from
// col_o; stimulus queues expected key codes and a monitor checks each handshake.
module tb_kpyd_scan_driver;

  logic        clk;
  logic        reset_i;
  logic [3:0]  row_i;
  logic [3:0]  col_o;
  logic [3:0]  key_o;
  logic        v_o;
  logic        ready_i;
  logic        pressed_o;

  logic [15:0] keys;
  int          exp_q[$];
  int          checks;
  int          errors;
  int          cyc;
  int          v_rise_cnt;
  int          last_rise_cyc;
  logic        prev_v;

  kpyd_scan_driver #(
    .cols_p(4), .rows_p(4), .settle_p(4), .debounce_p(3), .repeat_p(8)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .row_i(row_i), .col_o(col_o),
    .key_o(key_o), .v_o(v_o), .ready_i(ready_i), .pressed_o(pressed_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Keypad matrix: a held key pulls its row low while its column is strobed.
  always_comb begin
    row_i = '1;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (keys[c*4 + r] && !col_o[c]) row_i[r] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_i) begin
      prev_v = 1'b0;
    end else begin
      if (v_o && !prev_v) begin
        v_rise_cnt++;
        last_rise_cyc = cyc;
      end
      if (v_o && ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got key_o=%0d, required no event", key_o);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (int'(key_o) != e) begin
            errors++;
            $display("FAIL handshake_key: got key_o=%0d, required %0d", key_o, e);
          end
        end
      end
      prev_v = v_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Leaves the bench just after the edge that returns the strobe to column 0.
  task automatic align_sweep();
    int k;
    k = 0;
    while (col_o == 4'b1110 && k < 40) begin tick(1); k++; end
    while (col_o != 4'b1110 && k < 40) begin tick(1); k++; end
    chk("align_sweep_timeout", (k < 40) ? 1 : 0, 1);
  endtask

  initial begin
    logic [3:0] pat [4];
    int base;
    int press_cyc;
    pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;
    checks = 0; errors = 0; cyc = 0; v_rise_cnt = 0; last_rise_cyc = 0; prev_v = 1'b0;
    keys = '0;
    ready_i = 1'b1;
    reset_i = 1'b1;
    tick(3);
    reset_i = 1'b0;

    // Reset state and idle column rotation
    chk("reset_col_o", int'(col_o), 4'b1110);
    chk("reset_v_o", int'(v_o), 0);
    chk("reset_key_o", int'(key_o), 0);
    chk("reset_pressed_o", int'(pressed_o), 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("col_seq_%0d", i), int'(col_o), int'(pat[i % 4]));
      tick(4);
    end
    tick(168);
    chk("idle_no_event", v_rise_cnt, 0);
    chk("idle_v_o", int'(v_o), 0);

    // Key 9 (col 2 / row 1), consumer always ready
    base = v_rise_cnt;
    align_sweep();
    exp_q.push_back(9);
    keys[9] = 1'b1;
    press_cyc = cyc;
    tick(100);
    chk("k9_one_event", v_rise_cnt - base, 1);
    chk_range("k9_latency", last_rise_cyc - press_cyc, 48, 67);
    chk("k9_pressed_held", int'(pressed_o), 1);
    keys[9] = 1'b0;
    tick(30);
    chk("k9_pressed_during_release", int'(pressed_o), 1);
    tick(30);
    chk("k9_pressed_cleared", int'(pressed_o), 0);
    chk("k9_still_one_event", v_rise_cnt - base, 1);

    // Key 3 (col 0 / row 3) with the consumer stalled past the release
    tick(20);
    base = v_rise_cnt;
    ready_i = 1'b0;
    exp_q.push_back(3);
    keys[3] = 1'b1;
    tick(80);
    chk("k3_v_o_waiting", int'(v_o), 1);
    chk("k3_key_o", int'(key_o), 3);
    keys[3] = 1'b0;
    tick(100);
    chk("k3_pressed_cleared_before_ack", int'(pressed_o), 0);
    chk("k3_v_o_still_high", int'(v_o), 1);
    chk("k3_key_o_stable", int'(key_o), 3);
    ready_i = 1'b1;
    tick(2);
    chk("k3_v_o_after_ack", int'(v_o), 0);
    tick(100);
    chk("k3_single_event", v_rise_cnt - base, 1);

    // Key 4 (col 1 / row 0) bouncing every 5 cycles, then steady
    base = v_rise_cnt;
    for (int i = 0; i < 6; i++) begin
      keys[4] = 1'b1; tick(5);
      keys[4] = 1'b0; tick(5);
    end
    chk("bounce_no_event", v_rise_cnt - base, 0);
    exp_q.push_back(4);
    keys[4] = 1'b1;
    tick(80);
    chk("bounce_settled_event", v_rise_cnt - base, 1);
    keys[4] = 1'b0;
    tick(80);
    chk("bounce_pressed_cleared", int'(pressed_o), 0);

    // Keys 5 and 14 together, then release 5 while 14 stays down
    base = v_rise_cnt;
    exp_q.push_back(5);
    keys[5] = 1'b1;
    keys[14] = 1'b1;
    tick(80);
    chk("multi_one_event", v_rise_cnt - base, 1);
    chk("multi_pressed", int'(pressed_o), 1);
    keys[5] = 1'b0;
    tick(100);
    chk("rollover_ignored", v_rise_cnt - base, 1);
    chk("rollover_pressed", int'(pressed_o), 1);
    keys[14] = 1'b0;
    tick(80);
    chk("rollover_released", int'(pressed_o), 0);
    chk("rollover_no_late_event", v_rise_cnt - base, 1);

    // Reset while an event waits for the consumer
    base = v_rise_cnt;
    ready_i = 1'b0;
    exp_q.push_back(9);
    keys[9] = 1'b1;
    tick(80);
    chk("rst_pending_v_o", int'(v_o), 1);
    reset_i = 1'b1;
    tick(1);
    chk("rst_col_o", int'(col_o), 4'b1110);
    chk("rst_v_o", int'(v_o), 0);
    chk("rst_key_o", int'(key_o), 0);
    chk("rst_pressed_o", int'(pressed_o), 0);
    exp_q.delete();
    keys[9] = 1'b0;
    tick(3);
    reset_i = 1'b0;
    ready_i = 1'b1;
    tick(100);
    chk("rst_pending_discarded", v_rise_cnt - base, 1);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
